// File: rtl/clk_activity_monitor.sv
// clk_activity_monitor: counts rising edges of an asynchronous clock I over WIN CLK cycles, flags slow/fast/stuck
// Ports: CLK reference clock, RST sync active-high reset, EN enable, I monitored clock,
//        CNT last window count, VALID update pulse, FAIL_LO/FAIL_HI range flags, STUCK no-edge flag
module clk_activity_monitor #(
    parameter int WIN       = 256,
    parameter int CNT_W     = 8,
    parameter int MIN_CNT   = 16,
    parameter int MAX_CNT   = 48,
    parameter int STUCK_LIM = 64
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic             I,
    output logic [CNT_W-1:0] CNT,
    output logic             VALID,
    output logic             FAIL_LO,
    output logic             FAIL_HI,
    output logic             STUCK
);
    localparam int WW = $clog2(WIN);
    localparam int IW = $clog2(STUCK_LIM + 1);
    localparam logic [WW-1:0]    WIN_LAST = WW'(WIN - 1);
    localparam logic [IW-1:0]    LIM      = IW'(STUCK_LIM);
    localparam logic [CNT_W-1:0] MIN_V    = CNT_W'(MIN_CNT);
    localparam logic [CNT_W-1:0] MAX_V    = CNT_W'(MAX_CNT);

    if (WIN < 4 || MIN_CNT > MAX_CNT || MAX_CNT >= (1 << CNT_W)) begin : g_param_check
        $error("clk_activity_monitor: invalid parameters");
    end

    typedef enum logic [1:0] {IDLE, FLUSH, MEASURE, REPORT} state_t;

    state_t           state;
    logic             s1, s2, s3, fl, rise;
    logic [WW-1:0]    win_cnt;
    logic [CNT_W-1:0] edge_cnt, cnt_nxt;
    logic [IW-1:0]    idle_cnt;

    always_comb begin
        rise    = s2 & ~s3;
        cnt_nxt = &edge_cnt ? edge_cnt : edge_cnt + CNT_W'(rise);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            s1       <= 1'b0;
            s2       <= 1'b0;
            s3       <= 1'b0;
            fl       <= 1'b0;
            win_cnt  <= '0;
            edge_cnt <= '0;
            idle_cnt <= '0;
            CNT      <= '0;
            VALID    <= 1'b0;
            FAIL_LO  <= 1'b0;
            FAIL_HI  <= 1'b0;
            STUCK    <= 1'b0;
        end else begin
            s1    <= I;
            s2    <= s1;
            s3    <= s2;
            VALID <= 1'b0;
            // idle counting runs only while staying active; leaving to IDLE clears STUCK
            if (state != IDLE && EN) begin
                idle_cnt <= rise ? '0 : (idle_cnt == LIM ? LIM : idle_cnt + IW'(1));
                STUCK    <= !rise && idle_cnt == LIM;
            end else begin
                idle_cnt <= '0;
                STUCK    <= 1'b0;
            end
            case (state)
                IDLE: begin
                    edge_cnt <= '0;
                    win_cnt  <= '0;
                    fl       <= 1'b0;
                    if (EN) state <= FLUSH;
                end
                FLUSH: begin
                    edge_cnt <= '0;
                    win_cnt  <= '0;
                    fl       <= 1'b1;
                    if (!EN) state <= IDLE;
                    else if (fl) state <= MEASURE;
                end
                MEASURE: begin
                    if (!EN) begin
                        state    <= IDLE;
                        edge_cnt <= '0;
                    end else begin
                        edge_cnt <= cnt_nxt;
                        win_cnt  <= win_cnt + WW'(1);
                        if (win_cnt == WIN_LAST) begin
                            state   <= REPORT;
                            VALID   <= 1'b1;
                            CNT     <= cnt_nxt;
                            FAIL_LO <= cnt_nxt < MIN_V;
                            FAIL_HI <= cnt_nxt > MAX_V;
                        end
                    end
                end
                REPORT: begin
                    // an edge seen here opens the next window so none are lost
                    edge_cnt <= CNT_W'(rise);
                    win_cnt  <= '0;
                    state    <= EN ? MEASURE : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_clk_activity_monitor.sv
// tb_clk_activity_monitor: scoreboard bench for clk_activity_monitor
module tb_clk_activity_monitor;
    typedef struct packed {
        int cyc;
        int cnt;
        bit lo;
        bit hi;
    } ev_t;

    logic clk = 1'b0, rst = 1'b1, en = 1'b0, en4 = 1'b0, i_sig = 1'b0;
    logic [7:0] cnt;
    logic       valid, lo, hi, stuck;
    logic [3:0] cnt4;
    logic       valid4, lo4, hi4, stuck4;
    int cyc = 0, per = 0, base = 0, pulse_k = -100, stop_k = 1 << 30;
    int errors = 0, checks = 0;
    ev_t exp_q[$], obs_q[$];

    clk_activity_monitor u_dut (
        .CLK(clk), .RST(rst), .EN(en), .I(i_sig),
        .CNT(cnt), .VALID(valid), .FAIL_LO(lo), .FAIL_HI(hi), .STUCK(stuck)
    );

    clk_activity_monitor #(.WIN(40), .CNT_W(4), .MIN_CNT(2), .MAX_CNT(10), .STUCK_LIM(8)) u_dut4 (
        .CLK(clk), .RST(rst), .EN(en4), .I(i_sig),
        .CNT(cnt4), .VALID(valid4), .FAIL_LO(lo4), .FAIL_HI(hi4), .STUCK(stuck4)
    );

    always #5 clk = ~clk;

    // value of I captured into s1 at edge k
    function automatic bit pat(int k);
        if (k >= stop_k) return 1'b0;
        if (k == pulse_k) return 1'b1;
        if (per == 0) return 1'b0;
        return (((k - base) % per + per) % per) < per / 2;
    endfunction

    // window j after EN seen at edge t+1: VALID at edge v, counts captures a..v-2
    function automatic ev_t win_exp(int t, int j, int w, int sat, int mn, int mx);
        ev_t e;
        int v, a, c;
        v = t + w + 3 + j * (w + 1);
        a = (j == 0) ? t + 2 : v - w - 2;
        c = 0;
        for (int k = a; k <= v - 2; k++) if (pat(k) && !pat(k - 1)) c++;
        if (c > sat) c = sat;
        e.cyc = v;
        e.cnt = c;
        e.lo = c < mn;
        e.hi = c > mx;
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (valid) obs_q.push_back('{cyc, int'(cnt), lo, hi});
        if (valid4) obs_q.push_back('{cyc, int'(cnt4), lo4, hi4});
        i_sig = pat(cyc + 1);
    endtask

    task automatic test_reset();
        int t;
        rst = 1'b1;
        en = 1'b1;
        per = 8;
        base = 0;
        repeat (3) begin
            step();
            checks++;
            if ({valid, lo, hi, stuck, cnt, valid4, lo4, hi4, stuck4, cnt4} !== 20'h0) begin
                errors++;
                $display("FAIL reset_outputs cyc=%0d got %h want 0", cyc,
                         {valid, lo, hi, stuck, cnt, valid4, lo4, hi4, stuck4, cnt4});
            end
        end
        rst = 1'b0;
        t = cyc;
        exp_q.push_back(win_exp(t, 0, 256, 255, 16, 48));
        while (cyc < t + 262) step();
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL reset_first_valid count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            ev_t o, x;
            o = obs_q.pop_front();
            x = exp_q.pop_front();
            checks++;
            if (o !== x) begin
                errors++;
                $display("FAIL reset_first_valid got cyc=%0d cnt=%0d lo=%0b hi=%0b want cyc=%0d cnt=%0d lo=%0b hi=%0b",
                         o.cyc, o.cnt, o.lo, o.hi, x.cyc, x.cnt, x.lo, x.hi);
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_rate(input int p, input int n);
        int t;
        en = 1'b0;
        per = 0;
        repeat (5) step();
        per = p;
        base = cyc + 1;
        t = cyc;
        en = 1'b1;
        i_sig = pat(cyc + 1);
        for (int j = 0; j < n; j++) exp_q.push_back(win_exp(t, j, 256, 255, 16, 48));
        while (cyc < t + 259 + (n - 1) * 257 + 5) step();
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL rate_p%0d count got %0d want %0d", p, obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            ev_t o, x;
            o = obs_q.pop_front();
            x = exp_q.pop_front();
            checks++;
            if (o !== x) begin
                errors++;
                $display("FAIL rate_p%0d got cyc=%0d cnt=%0d lo=%0b hi=%0b want cyc=%0d cnt=%0d lo=%0b hi=%0b",
                         p, o.cyc, o.cnt, o.lo, o.hi, x.cyc, x.cnt, x.lo, x.hi);
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_stuck();
        int t;
        en = 1'b0;
        per = 0;
        repeat (5) step();
        t = cyc;
        pulse_k = t + 300;
        en = 1'b1;
        i_sig = pat(cyc + 1);
        for (int j = 0; j < 2; j++) exp_q.push_back(win_exp(t, j, 256, 255, 16, 48));
        while (cyc < t + 65) step();
        checks++;
        if (stuck !== 1'b0) begin
            errors++;
            $display("FAIL stuck_early got %b want 0", stuck);
        end
        step();
        checks++;
        if (stuck !== 1'b1) begin
            errors++;
            $display("FAIL stuck_assert got %b want 1", stuck);
        end
        while (cyc < t + 301) step();
        checks++;
        if (stuck !== 1'b1) begin
            errors++;
            $display("FAIL stuck_before_pulse got %b want 1", stuck);
        end
        step();
        checks++;
        if (stuck !== 1'b0) begin
            errors++;
            $display("FAIL stuck_clear got %b want 0", stuck);
        end
        while (cyc < t + 521) step();
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL stuck_windows count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            ev_t o, x;
            o = obs_q.pop_front();
            x = exp_q.pop_front();
            checks++;
            if (o !== x) begin
                errors++;
                $display("FAIL stuck_windows got cyc=%0d cnt=%0d lo=%0b hi=%0b want cyc=%0d cnt=%0d lo=%0b hi=%0b",
                         o.cyc, o.cnt, o.lo, o.hi, x.cyc, x.cnt, x.lo, x.hi);
            end
        end
        obs_q.delete();
        exp_q.delete();
        pulse_k = -100;
    endtask

    task automatic test_abort();
        ev_t e;
        int t;
        en = 1'b0;
        per = 0;
        repeat (5) step();
        per = 4;
        base = cyc + 1;
        t = cyc;
        stop_k = t + 280;
        en = 1'b1;
        i_sig = pat(cyc + 1);
        e = win_exp(t, 0, 256, 255, 16, 48);
        exp_q.push_back(e);
        while (cyc < t + 360) step();
        checks++;
        if (stuck !== 1'b1) begin
            errors++;
            $display("FAIL abort_stuck_before got %b want 1", stuck);
        end
        en = 1'b0;
        step();
        checks++;
        if ({valid, stuck} !== 2'b00 || cnt !== 8'(e.cnt) || lo !== e.lo || hi !== e.hi) begin
            errors++;
            $display("FAIL abort_hold got valid=%b stuck=%b cnt=%0d lo=%b hi=%b want valid=0 stuck=0 cnt=%0d lo=%b hi=%b",
                     valid, stuck, cnt, lo, hi, e.cnt, e.lo, e.hi);
        end
        repeat (300) step();
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL abort_windows count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            ev_t o, x;
            o = obs_q.pop_front();
            x = exp_q.pop_front();
            checks++;
            if (o !== x) begin
                errors++;
                $display("FAIL abort_windows got cyc=%0d cnt=%0d lo=%0b hi=%0b want cyc=%0d cnt=%0d lo=%0b hi=%0b",
                         o.cyc, o.cnt, o.lo, o.hi, x.cyc, x.cnt, x.lo, x.hi);
            end
        end
        obs_q.delete();
        exp_q.delete();
        stop_k = 1 << 30;
    endtask

    task automatic test_rst_mid();
        int t;
        per = 8;
        base = cyc + 1;
        t = cyc;
        en = 1'b1;
        i_sig = pat(cyc + 1);
        exp_q.push_back(win_exp(t, 0, 256, 255, 16, 48));
        while (cyc < t + 359) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        en = 1'b0;
        checks++;
        if ({valid, lo, hi, stuck, cnt} !== 12'h0) begin
            errors++;
            $display("FAIL rst_mid_outputs got %h want 0", {valid, lo, hi, stuck, cnt});
        end
        repeat (5) step();
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL rst_mid_windows count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            ev_t o, x;
            o = obs_q.pop_front();
            x = exp_q.pop_front();
            checks++;
            if (o !== x) begin
                errors++;
                $display("FAIL rst_mid_windows got cyc=%0d cnt=%0d lo=%0b hi=%0b want cyc=%0d cnt=%0d lo=%0b hi=%0b",
                         o.cyc, o.cnt, o.lo, o.hi, x.cyc, x.cnt, x.lo, x.hi);
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_small(input int p, input int pk);
        int t;
        en = 1'b0;
        en4 = 1'b0;
        per = 0;
        repeat (5) step();
        per = p;
        base = cyc + 1;
        t = cyc;
        pulse_k = (pk < 0) ? -100 : t + pk;
        en4 = 1'b1;
        i_sig = pat(cyc + 1);
        for (int j = 0; j < 2; j++) exp_q.push_back(win_exp(t, j, 40, 15, 2, 10));
        while (cyc < t + 43 + 41 + 5) step();
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL small_p%0d count got %0d want %0d", p, obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            ev_t o, x;
            o = obs_q.pop_front();
            x = exp_q.pop_front();
            checks++;
            if (o !== x) begin
                errors++;
                $display("FAIL small_p%0d got cyc=%0d cnt=%0d lo=%0b hi=%0b want cyc=%0d cnt=%0d lo=%0b hi=%0b",
                         p, o.cyc, o.cnt, o.lo, o.hi, x.cyc, x.cnt, x.lo, x.hi);
            end
        end
        obs_q.delete();
        exp_q.delete();
        en4 = 1'b0;
        pulse_k = -100;
    endtask

    initial begin
        test_reset();
        test_rate(8, 3);
        test_rate(20, 2);
        test_rate(4, 2);
        test_stuck();
        test_abort();
        test_rst_mid();
        test_small(2, -1);
        test_small(0, 42);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
